// File: rtl/reg_pipe_hs.sv
// Multi-stage pipeline register with valid/ready handshake, flush and occupancy count.
// Empty stages accept from upstream in the same edge, so bubbles collapse toward the output.
module reg_pipe_hs #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RSTN_VALUE = '0,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_count
);

  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0]      ld;
  logic [DATA_WIDTH-1:0] dat [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  in_fire;
  logic                  out_fire;

  // Load enables ripple from the output stage back to the input stage.
  always_comb begin : ld_chain
    logic chain;
    ld    = '0;
    chain = i_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      chain = !vld[k] | chain;
      ld[k] = chain;
    end
  end

  assign o_ready  = ld[0] & ~i_flush;
  assign in_fire  = i_valid & o_ready;
  assign o_valid  = vld[DEPTH-1];
  assign out_fire = o_valid & i_ready;
  assign o_data   = dat[DEPTH-1];
  assign o_count  = cnt;

  // Stage registers; flush clears valids only and leaves payloads untouched.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld <= '0;
      for (int k = 0; k < int'(DEPTH); k++) dat[k] <= RSTN_VALUE;
    end else if (i_flush) begin
      vld <= '0;
    end else begin
      if (ld[0]) begin
        vld[0] <= in_fire;
        if (in_fire) dat[0] <= i_data;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (ld[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) dat[k] <= dat[k-1];
        end
      end
    end
  end

  // Occupancy counter tracks popcount(vld).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      cnt <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   cnt <= cnt + CNT_WIDTH'(1);
        2'b01:   cnt <= cnt - CNT_WIDTH'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Directed and randomized checks for reg_pipe_hs with DEPTH=3 and RSTN_VALUE=32'hDEAD.
module tb_reg_pipe_hs;

  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 3;
  localparam logic [DW-1:0] RV = 32'hDEAD;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_flush;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;
  logic [1:0]    o_count;

  int total = 0;
  int bad = 0;
  int t2_cnt [8] = '{0, 1, 2, 3, 2, 1, 0, 0};
  logic [DW-1:0] q [$];
  int mcnt;

  reg_pipe_hs #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RSTN_VALUE(RV)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_count(o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    cyc(); cyc();
    i_rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", o_data, 32'hDEAD);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_count", 32'(o_count), 32'd0);

    // back-to-back stream, downstream always ready
    i_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      i_valid = (c < 3);
      i_data = 32'(17 * (c + 1));
      #1;
      chk("t2_valid", 32'(o_valid), 32'(c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) chk("t2_data", o_data, 32'(17 * (c - 2)));
      chk("t2_count", 32'(o_count), 32'(t2_cnt[c]));
      cyc();
    end

    // fill while stalled, then push and pop together
    i_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_valid = 1'b1;
      i_data = 32'(c + 1);
      #1;
      chk("t3_ready", 32'(o_ready), 32'(c < 3));
      if (c == 3) begin
        chk("t3_full_count", 32'(o_count), 32'd3);
        chk("t3_full_valid", 32'(o_valid), 32'd1);
        chk("t3_full_data", o_data, 32'h01);
      end
      cyc();
    end
    i_ready = 1'b1; i_valid = 1'b1; i_data = 32'h04;
    #1;
    chk("t3_swap_ready", 32'(o_ready), 32'd1);
    chk("t3_swap_data", o_data, 32'h01);
    cyc();
    i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t3_drain_count", 32'(o_count), 32'(3 - c));
      chk("t3_drain_valid", 32'(o_valid), 32'(c < 3));
      if (c < 3) chk("t3_drain_data", o_data, 32'(c + 2));
      cyc();
    end

    // bubble collapse while stalled
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_valid = (c == 0 || c == 2);
      i_data = (c == 0) ? 32'hA1 : 32'hA2;
      #1;
      if (c >= 3) begin
        chk("t4_valid", 32'(o_valid), 32'd1);
        chk("t4_data", o_data, 32'hA1);
        chk("t4_count", 32'(o_count), 32'd2);
      end
      if (c == 4) chk("t4_ready", 32'(o_ready), 32'd1);
      cyc();
    end

    // flush with an offered entry
    i_flush = 1'b1; i_valid = 1'b1; i_data = 32'h55;
    #1;
    chk("t5_flush_ready", 32'(o_ready), 32'd0);
    cyc();
    i_flush = 1'b0; i_valid = 1'b0;
    #1;
    chk("t5_valid", 32'(o_valid), 32'd0);
    chk("t5_count", 32'(o_count), 32'd0);
    chk("t5_ready", 32'(o_ready), 32'd1);
    chk("t5_data_kept", o_data, 32'hA1);
    i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("t5_no_emerge", 32'(o_valid), 32'd0);
    end

    // reset in the middle of a stream
    i_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i_valid = (c < 2);
      i_data = (c == 0) ? 32'hB1 : 32'hB2;
      #1;
      if (c == 3) begin
        chk("t6_pre_valid", 32'(o_valid), 32'd1);
        chk("t6_pre_data", o_data, 32'hB1);
        chk("t6_pre_count", 32'(o_count), 32'd2);
      end
      cyc();
    end
    i_rst_n = 1'b0; i_valid = 1'b1; i_data = 32'hB3;
    cyc();
    i_rst_n = 1'b1; i_valid = 1'b0;
    #1;
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_data", o_data, 32'hDEAD);
    chk("t6_count", 32'(o_count), 32'd0);

    // random traffic against a queue scoreboard
    mcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = ($urandom_range(0, 99) < 60);
      i_data = $urandom;
      #1;
      chk("rnd_ready", 32'(o_ready), 32'((mcnt < 3) || i_ready));
      chk("rnd_count", 32'(o_count), 32'(mcnt));
      chk("rnd_valid_empty", 32'(o_valid && (mcnt == 0)), 32'd0);
      if (o_valid && i_ready) begin
        chk("rnd_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("rnd_data", o_data, q.pop_front());
        mcnt--;
      end
      if (i_valid && o_ready) begin
        q.push_back(i_data);
        mcnt++;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
